color_box_detect: RTL and testbench

- Per-frame color-key bounding-box detector and producer of the box coordinates consumed by the overlay stage.
- Taps the packed HDMI stream (same pack format as the rest of the video path) and tracks the min/max x/y of pixels matching a key color within a tolerance.
- At each frame boundary, publishes one box (start/end corners, pixel count) in the format the box-drawing stage accepts: all-zero coordinates mean "no box".
- Passes the video stream through, registered, so it can sit inline ahead of the overlay.

---
 rtl/color_box_detect_if.sv | 9 +
 rtl/color_box_detect.sv | 237 +++++++++++++++++++++++
 tb/tb_color_box_detect.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_box_detect_if.sv
// Packed video bus (hsync, vsync, de, clk, r, g, b, x, y) shared by the video path stages.
interface color_box_detect_if #(
  parameter int unsigned PW = 49
) ();
  logic [PW-1:0] pack;

  modport master (output pack);
  modport slave  (input  pack);
endinterface

// File: rtl/color_box_detect.sv
// Per-frame color-key bounding-box detector with registered video pass-through.
// Optional macro DETECT_HOLD_EN: hold the last box for up to HOLD_FRAMES failing frames.
module color_box_detect #(
  parameter int unsigned H_ACT       = 1280,
  parameter int unsigned V_ACT       = 720,
  parameter int unsigned MIN_PIXELS  = 64,
  parameter int unsigned HOLD_FRAMES = 4,
  localparam int unsigned XW = $clog2(H_ACT),
  localparam int unsigned YW = $clog2(V_ACT),
  localparam int unsigned CW = $clog2(H_ACT * V_ACT) + 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  color_box_detect_if.slave         i_pack,
  color_box_detect_if.master        o_pack,
  input  logic [23:0]               key_color,
  input  logic [7:0]                tolerance,
  output logic [XW-1:0]             start_x,
  output logic [YW-1:0]             start_y,
  output logic [XW-1:0]             end_x,
  output logic [YW-1:0]             end_y,
  output logic [CW-1:0]             pixel_count,
  output logic                      box_valid
);

  localparam int unsigned PW    = 28 + XW + YW;
  localparam int unsigned BLo   = XW + YW;
  localparam int unsigned GLo   = BLo + 8;
  localparam int unsigned RLo   = GLo + 8;
  localparam int unsigned DeBit = RLo + 9;
  localparam int unsigned VsBit = RLo + 10;

  localparam logic [1:0] StWaitFrame = 2'd0;
  localparam logic [1:0] StAccum     = 2'd1;
  localparam logic [1:0] StCommit    = 2'd2;

  localparam logic [XW-1:0] MinXInit = XW'(H_ACT - 1);
  localparam logic [YW-1:0] MinYInit = YW'(V_ACT - 1);

  if (HOLD_FRAMES < 1) begin : g_param_check
    $error("HOLD_FRAMES must be at least 1");
  end

  // 9-bit difference so no channel wraps around.
  function automatic logic within_tol(logic [7:0] a, logic [7:0] b, logic [7:0] tol);
    logic [8:0] d;
    d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return d <= {1'b0, tol};
  endfunction

  logic [7:0]    px_r, px_g, px_b;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic          px_de, px_vs, match_d;

  assign px_y  = i_pack.pack[YW-1:0];
  assign px_x  = i_pack.pack[YW +: XW];
  assign px_b  = i_pack.pack[BLo +: 8];
  assign px_g  = i_pack.pack[GLo +: 8];
  assign px_r  = i_pack.pack[RLo +: 8];
  assign px_de = i_pack.pack[DeBit];
  assign px_vs = i_pack.pack[VsBit];

  assign match_d = en & px_de
                 & within_tol(px_r, key_color[23:16], tolerance)
                 & within_tol(px_g, key_color[15:8], tolerance)
                 & within_tol(px_b, key_color[7:0], tolerance);

  // Stage 1: registered unpack and pass-through.
  logic [PW-1:0] pack_q;
  logic          match_q, vs_q, vs_q2;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pack_q  <= '0;
      match_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      vs_q    <= 1'b0;
      vs_q2   <= 1'b0;
    end else begin
      pack_q  <= i_pack.pack;
      match_q <= match_d;
      x_q     <= px_x;
      y_q     <= px_y;
      vs_q    <= px_vs;
      vs_q2   <= vs_q;
    end
  end

  assign o_pack.pack = pack_q;

  logic boundary;
  assign boundary = vs_q & ~vs_q2;

  // Stage 2: accumulate, commit at frame boundary.
  logic [1:0]    state_q, state_d;
  logic [XW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [YW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] sx_q, sx_d, ex_q, ex_d;
  logic [YW-1:0] sy_q, sy_d, ey_q, ey_d;
  logic [CW-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  logic          pass;

`ifdef DETECT_HOLD_EN
  localparam int unsigned MW = $clog2(HOLD_FRAMES + 1);
  logic [MW-1:0] miss_q, miss_d;
`endif

  assign pass = (cnt_q >= CW'(MIN_PIXELS));

  always_comb begin
    state_d = state_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    cnt_d   = cnt_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    pc_d    = pc_q;
    valid_d = 1'b0;
`ifdef DETECT_HOLD_EN
    miss_d  = miss_q;
`endif
    unique case (state_q)
      StWaitFrame: begin
        if (boundary) begin
          state_d = StAccum;
          min_x_d = MinXInit;
          max_x_d = '0;
          min_y_d = MinYInit;
          max_y_d = '0;
          cnt_d   = '0;
        end
      end
      StAccum: begin
        // A match in the boundary-detect cycle still belongs to the closing frame.
        if (match_q) begin
          if (x_q < min_x_q) min_x_d = x_q;
          if (x_q > max_x_q) max_x_d = x_q;
          if (y_q < min_y_q) min_y_d = y_q;
          if (y_q > max_y_q) max_y_d = y_q;
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        end
        if (boundary) state_d = StCommit;
      end
      StCommit: begin
        valid_d = 1'b1;
        pc_d    = cnt_q;
        if (pass) begin
          sx_d = min_x_q;
          sy_d = min_y_q;
          ex_d = max_x_q;
          ey_d = max_y_q;
`ifdef DETECT_HOLD_EN
          miss_d = '0;
`endif
        end else begin
`ifdef DETECT_HOLD_EN
          if (miss_q < MW'(HOLD_FRAMES)) begin
            miss_d = miss_q + MW'(1);
          end else begin
            sx_d = '0;
            sy_d = '0;
            ex_d = '0;
            ey_d = '0;
          end
`else
          sx_d = '0;
          sy_d = '0;
          ex_d = '0;
          ey_d = '0;
`endif
        end
        min_x_d = MinXInit;
        max_x_d = '0;
        min_y_d = MinYInit;
        max_y_d = '0;
        cnt_d   = '0;
        state_d = StAccum;
      end
      default: state_d = StWaitFrame;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StWaitFrame;
      min_x_q <= MinXInit;
      max_x_q <= '0;
      min_y_q <= MinYInit;
      max_y_q <= '0;
      cnt_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
`ifdef DETECT_HOLD_EN
      miss_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      cnt_q   <= cnt_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
`ifdef DETECT_HOLD_EN
      miss_q  <= miss_d;
`endif
    end
  end

  assign start_x     = sx_q;
  assign start_y     = sy_q;
  assign end_x       = ex_q;
  assign end_y       = ey_q;
  assign pixel_count = pc_q;
  assign box_valid   = valid_q;

endmodule

// File: tb/tb_color_box_detect.sv
// Bench for color_box_detect: three instances (MIN_PIXELS 64/256/1) against a frame-level model.
module tb_color_box_detect;
  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned CW = 21;
  localparam int unsigned PW = 49;
  localparam int NI = 3;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rstn, en;
  logic [23:0] key;
  logic [7:0] tol;

  always #5 clk = ~clk;

  color_box_detect_if #(.PW(PW)) vin ();
  color_box_detect_if #(.PW(PW)) vout0 ();
  color_box_detect_if #(.PW(PW)) vout1 ();
  color_box_detect_if #(.PW(PW)) vout2 ();

  logic [NI-1:0][XW-1:0] sx, ex;
  logic [NI-1:0][YW-1:0] sy, ey;
  logic [NI-1:0][CW-1:0] pc;
  logic [NI-1:0]         bv;
  logic [NI-1:0][PW-1:0] op;

  assign op[0] = vout0.pack;
  assign op[1] = vout1.pack;
  assign op[2] = vout2.pack;

  color_box_detect u_dut0 (
    .clk(clk), .rstn(rstn), .en(en), .i_pack(vin.slave), .o_pack(vout0.master),
    .key_color(key), .tolerance(tol), .start_x(sx[0]), .start_y(sy[0]), .end_x(ex[0]),
    .end_y(ey[0]), .pixel_count(pc[0]), .box_valid(bv[0])
  );
  color_box_detect #(.MIN_PIXELS(256)) u_dut1 (
    .clk(clk), .rstn(rstn), .en(en), .i_pack(vin.slave), .o_pack(vout1.master),
    .key_color(key), .tolerance(tol), .start_x(sx[1]), .start_y(sy[1]), .end_x(ex[1]),
    .end_y(ey[1]), .pixel_count(pc[1]), .box_valid(bv[1])
  );
  color_box_detect #(.MIN_PIXELS(1)) u_dut2 (
    .clk(clk), .rstn(rstn), .en(en), .i_pack(vin.slave), .o_pack(vout2.master),
    .key_color(key), .tolerance(tol), .start_x(sx[2]), .start_y(sy[2]), .end_x(ex[2]),
    .end_y(ey[2]), .pixel_count(pc[2]), .box_valid(bv[2])
  );

  int n_vec = 0;
  int n_fail = 0;
  int n_pulse = 0;
  bit chk_on = 1'b0;

  task automatic check(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int minp(int i);
    return (i == 0) ? 64 : (i == 1) ? 256 : 1;
  endfunction

  // ---------------- frame-level model ----------------
  logic [PW-1:0] exp_op;
  int e_sx[NI], e_sy[NI], e_ex[NI], e_ey[NI], e_pc[NI], miss[NI];
  bit e_valid;
  int f_cnt, f_minx, f_maxx, f_miny, f_maxy;
  int s_cnt, s_minx, s_maxx, s_miny, s_maxy;
  bit armed, vs_prev, pending;
  longint edge_n = 0, commit_edge;

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic clear_frame();
    f_cnt = 0; f_minx = 100000; f_maxx = -1; f_miny = 100000; f_maxy = -1;
  endtask

  task automatic apply_commit();
    for (int i = 0; i < NI; i++) begin
      e_pc[i] = s_cnt;
      if (s_cnt >= minp(i)) begin
        e_sx[i] = s_minx; e_sy[i] = s_miny; e_ex[i] = s_maxx; e_ey[i] = s_maxy;
        miss[i] = 0;
      end else begin
`ifdef DETECT_HOLD_EN
        if (miss[i] < HOLD) miss[i]++;
        else begin e_sx[i] = 0; e_sy[i] = 0; e_ex[i] = 0; e_ey[i] = 0; end
`else
        e_sx[i] = 0; e_sy[i] = 0; e_ex[i] = 0; e_ey[i] = 0;
`endif
      end
    end
    e_valid = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      e_valid = 1'b0;
      if (!rstn) begin
        exp_op = '0;
        for (int i = 0; i < NI; i++) begin
          e_sx[i] = 0; e_sy[i] = 0; e_ex[i] = 0; e_ey[i] = 0; e_pc[i] = 0; miss[i] = 0;
        end
        clear_frame();
        armed = 1'b0; vs_prev = 1'b0; pending = 1'b0;
      end else begin
        logic [PW-1:0] p;
        int r, g, b, x, y;
        bit de, vs;
        p = vin.pack;
        exp_op = p;
        if (pending && edge_n == commit_edge) begin
          apply_commit();
          pending = 1'b0;
        end
        de = p[PW-3]; vs = p[PW-2];
        r = int'(p[YW+XW+16 +: 8]); g = int'(p[YW+XW+8 +: 8]); b = int'(p[YW+XW +: 8]);
        x = int'(p[YW +: XW]); y = int'(p[0 +: YW]);
        if (en && de && absd(r, int'(key[23:16])) <= int'(tol)
            && absd(g, int'(key[15:8])) <= int'(tol) && absd(b, int'(key[7:0])) <= int'(tol)) begin
          f_cnt++;
          if (x < f_minx) f_minx = x;
          if (x > f_maxx) f_maxx = x;
          if (y < f_miny) f_miny = y;
          if (y > f_maxy) f_maxy = y;
        end
        if (vs && !vs_prev) begin
          if (armed) begin
            pending = 1'b1; commit_edge = edge_n + 2;
            s_cnt = f_cnt; s_minx = f_minx; s_maxx = f_maxx; s_miny = f_miny; s_maxy = f_maxy;
          end
          armed = 1'b1;
          clear_frame();
        end
        vs_prev = vs;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        if (bv[0]) n_pulse++;
        for (int i = 0; i < NI; i++) begin
          check($sformatf("o_pack%0d", i), longint'(op[i]), longint'(exp_op));
          check($sformatf("start_x%0d", i), longint'(sx[i]), e_sx[i]);
          check($sformatf("start_y%0d", i), longint'(sy[i]), e_sy[i]);
          check($sformatf("end_x%0d", i), longint'(ex[i]), e_ex[i]);
          check($sformatf("end_y%0d", i), longint'(ey[i]), e_ey[i]);
          check($sformatf("pixel_count%0d", i), longint'(pc[i]), e_pc[i]);
          check($sformatf("box_valid%0d", i), longint'(bv[i]), longint'(e_valid));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [23:0] Key = 24'hFF8000;

  function automatic logic [PW-1:0] mk(logic hs, logic vs, logic de, logic [23:0] rgb,
                                        int x, int y);
    return {hs, vs, de, 1'b1, rgb, XW'(x), YW'(y)};
  endfunction

  task automatic drive(logic [PW-1:0] p);
    @(posedge clk);
    #1 vin.pack = p;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive('0);
  endtask

  task automatic vsync_pulse();
    idle(2);
    for (int i = 0; i < 3; i++) drive(mk(1'b0, 1'b1, 1'b0, 24'h0, 0, 0));
    idle(2);
  endtask

  // 20x10 key-colored block at x=100..119, y=50..59 plus non-matching decoys.
  task automatic block_rows(int y0, int y1);
    for (int y = y0; y <= y1; y++) begin
      drive(mk(1'b0, 1'b0, 1'b1, 24'h000000, 99, y));
      for (int x = 100; x < 120; x++) drive(mk(1'b0, 1'b0, 1'b1, Key, x, y));
      drive(mk(1'b0, 1'b0, 1'b0, Key, 300, y));
      drive(mk(1'b1, 1'b0, 1'b0, 24'h0, 0, y));
    end
  endtask

  task automatic pin_box(int i, int x0, int y0, int x1, int y1, int c);
    check($sformatf("pin_sx%0d", i), longint'(sx[i]), x0);
    check($sformatf("pin_sy%0d", i), longint'(sy[i]), y0);
    check($sformatf("pin_ex%0d", i), longint'(ex[i]), x1);
    check($sformatf("pin_ey%0d", i), longint'(ey[i]), y1);
    check($sformatf("pin_pc%0d", i), longint'(pc[i]), c);
  endtask

  int p0;

  initial begin
    rstn = 1'b0; en = 1'b1; key = Key; tol = 8'd0; vin.pack = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    check("reset_opack", longint'(op[0]), 0);
    pin_box(0, 0, 0, 0, 0, 0);

    // Partial frame before the first boundary is discarded.
    block_rows(50, 59);
    vsync_pulse();
    @(negedge clk);
    check("first_boundary_pulses", n_pulse, 0);
    check("first_boundary_pc", longint'(pc[0]), 0);

    p0 = n_pulse;
    block_rows(50, 59);
    vsync_pulse();
    @(negedge clk);
    check("frame1_pulses", n_pulse - p0, 1);
    pin_box(0, 100, 50, 119, 59, 200);
    pin_box(1, 0, 0, 0, 0, 200);
    pin_box(2, 100, 50, 119, 59, 200);
    check("model_sx0", e_sx[0], 100);
    check("model_pc0", e_pc[0], 200);

    // Tolerance edge: only the pixel at x=10 is within 8 on every channel.
    key = {8'd200, 8'd40, 8'd40}; tol = 8'd8;
    drive(mk(1'b0, 1'b0, 1'b1, {8'd208, 8'd32, 8'd48}, 10, 5));
    drive(mk(1'b0, 1'b0, 1'b1, {8'd209, 8'd40, 8'd40}, 11, 5));
    idle(1);
    vsync_pulse();
    @(negedge clk);
    pin_box(2, 10, 5, 10, 5, 1);
    check("tol_pc0", longint'(pc[0]), 1);
    check("model_ex2", e_ex[2], 10);
    key = Key; tol = 8'd0;

    // en=0 frame commits a zero count; re-enabling restores the box.
    en = 1'b0;
    block_rows(50, 59);
    vsync_pulse();
    @(negedge clk);
    check("en0_pc0", longint'(pc[0]), 0);
`ifndef DETECT_HOLD_EN
    check("en0_sx0", longint'(sx[0]), 0);
    check("en0_ey0", longint'(ey[0]), 0);
`endif
    en = 1'b1;
    block_rows(50, 59);
    vsync_pulse();
    @(negedge clk);
    pin_box(0, 100, 50, 119, 59, 200);

    // Mid-frame reset: outputs clear, next boundary only re-arms.
    block_rows(50, 54);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    pin_box(0, 0, 0, 0, 0, 0);
    block_rows(55, 59);
    p0 = n_pulse;
    vsync_pulse();
    @(negedge clk);
    check("rst_discard_pulses", n_pulse - p0, 0);
    block_rows(50, 59);
    vsync_pulse();
    @(negedge clk);
    check("rst_commit_pulses", n_pulse - p0, 1);
    pin_box(0, 100, 50, 119, 59, 200);

    // One good frame (above) then five empty frames.
    for (int f = 1; f <= 5; f++) begin
      idle(4);
      vsync_pulse();
      @(negedge clk);
      check($sformatf("hold_pc_f%0d", f), longint'(pc[0]), 0);
`ifdef DETECT_HOLD_EN
      check($sformatf("hold_sx_f%0d", f), longint'(sx[0]), (f <= HOLD) ? 100 : 0);
`else
      check($sformatf("hold_sx_f%0d", f), longint'(sx[0]), 0);
`endif
    end

    idle(4);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
